// File: rtl/inst_fetch.sv
// Instruction fetch unit: drives a two-phase memory read (load pulse, data
// one cycle later), buffers fetched words in a 2-entry {pc, inst} FIFO and
// presents the FIFO head to decode with a valid/ready handshake.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        load,
  output logic [31:0] addr,
  input  logic [31:0] data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  // start_q delays the first request by one cycle after reset release
  logic start_q, start_d;

  logic [31:0] pc_q, pc_d;
  logic        load_q, load_d;
  logic [31:0] addr_q, addr_d;

  logic [1:0][31:0] fifo_pc_q, fifo_pc_d;
  logic [1:0][31:0] fifo_inst_q, fifo_inst_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;

  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic       pop_s;
  logic       push_s;
  logic [1:0] cnt_after_pop_s;
  logic [1:0] cnt_after_push_s;
  logic       room_idle_s;
  logic       room_wait_s;

  // Handshake and room evaluation; count never exceeds 1 while in WAIT,
  // so the post-push count fits in two bits.
  always_comb begin
    pop_s            = inst_valid_q & inst_ready;
    push_s           = (state_q == WAIT) & ~redirect;
    cnt_after_pop_s  = count_q - {1'b0, pop_s};
    cnt_after_push_s = cnt_after_pop_s + 2'd1;
    room_idle_s      = (cnt_after_pop_s < 2'd2);
    room_wait_s      = (cnt_after_push_s < 2'd2);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; redirect always parks the FSM in IDLE
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_q && room_idle_s) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
        REQ: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (room_wait_s) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output and datapath next values: pc, FIFO, and registered outputs
  always_comb begin
    start_d     = 1'b1;
    pc_d        = pc_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    if (redirect) begin
      // Flush everything, including a word still in flight
      pc_d     = {redirect_pc[31:2], 2'b00};
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_s) begin
        fifo_pc_d[wr_ptr_q]   = pc_q;
        fifo_inst_d[wr_ptr_q] = data;
        wr_ptr_d              = ~wr_ptr_q;
        pc_d                  = pc_q + 32'd4;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
    end

    // The address only moves when a request is being launched
    load_d = (state_d == REQ);
    if (state_d == REQ) begin
      addr_d = pc_d;
    end else begin
      addr_d = addr_q;
    end

    inst_valid_d = (count_d != 2'd0);
    inst_d       = fifo_inst_d[rd_ptr_d];
    inst_pc_d    = fifo_pc_d[rd_ptr_d];
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q      <= 1'b0;
      pc_q         <= RESET_PC;
      load_q       <= 1'b0;
      addr_q       <= RESET_PC;
      fifo_pc_q    <= '0;
      fifo_inst_q  <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
    end else begin
      start_q      <= start_d;
      pc_q         <= pc_d;
      load_q       <= load_d;
      addr_q       <= addr_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_inst_q  <= fifo_inst_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign load       = load_q;
  assign addr       = addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory model plus expected-word
// scoreboard, with directed timing, stall, redirect and reset scenarios.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [31:0] addr;
  logic [31:0] data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int checks = 0;
  int failures = 0;
  int pops = 0;

  logic [31:0] lat_addr = 32'd0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_fetch = RST_PC;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .addr       (addr),
    .data       (data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0000_0093;
    else if (a == 32'h0000_0004) return 32'h0010_0113;
    else return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory samples the address when load falls; data is held afterwards
  initial begin
    forever begin
      @(negedge load);
      lat_addr = addr;
    end
  end
  assign data = mem_word(lat_addr);

  // Scoreboard: record each issued read, compare each accepted instruction
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        exp_fetch = RST_PC;
      end else begin
        if (inst_valid && inst_ready) begin
          check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("sb_inst_pc", inst_pc, e[63:32]);
            check_eq("sb_inst", inst, e[31:0]);
          end
          pops++;
        end
        if (redirect) begin
          sb_q.delete();
          exp_fetch = {redirect_pc[31:2], 2'b00};
        end else if (load) begin
          check_eq("fetch_addr", addr, exp_fetch);
          sb_q.push_back({addr, mem_word(addr)});
          exp_fetch = exp_fetch + 32'd4;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_load(input string tag);
    for (int i = 0; i < 20; i++) begin
      step();
      if (load) break;
    end
    check_eq(tag, load, 32'd1);
  endtask

  initial begin
    int p0;
    rst_n       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    inst_ready  = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    // Reset state
    check_eq("rst_valid", inst_valid, 32'd0);
    check_eq("rst_load", load, 32'd0);
    check_eq("rst_addr", addr, RST_PC);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_inst_pc", inst_pc, 32'd0);

    // Release and first-fetch timing
    step(); step();
    rst_n = 1'b1;
    step(); check_eq("t1_no_req_edge1", load, 32'd0);
    step(); check_eq("t1_req_edge2", load, 32'd1);
    check_eq("t1_req_addr", addr, RST_PC);
    step(); check_eq("t1_wait_valid", inst_valid, 32'd0);
    step(); check_eq("t1_valid0", inst_valid, 32'd1);
    check_eq("t1_pc0", inst_pc, 32'h0000_0000);
    check_eq("t1_inst0", inst, 32'h0000_0093);
    step(); check_eq("t1_gap", inst_valid, 32'd0);
    step(); check_eq("t1_valid1", inst_valid, 32'd1);
    check_eq("t1_pc1", inst_pc, 32'h0000_0004);
    check_eq("t1_inst1", inst, 32'h0010_0113);

    // Stall: decode not ready, FIFO fills with two words then parks
    rst_n = 1'b0;
    inst_ready = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (12) step();
    check_eq("t2_fetched", 32'(sb_q.size()), 32'd2);
    check_eq("t2_head_pc", inst_pc, 32'h0000_0000);
    check_eq("t2_valid", inst_valid, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_parked_load", load, 32'd0);
      step();
    end
    inst_ready = 1'b1;
    wait_load("t2_resume");
    check_eq("t2_resume_addr", addr, 32'h0000_0008);

    // Redirect during WAIT
    wait_load("t3_req");
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    check_eq("t3_flush", inst_valid, 32'd0);
    wait_load("t3_refetch");
    check_eq("t3_addr", addr, 32'h0000_0100);

    // Redirect to the top of the address space: pc wraps
    inst_ready = 1'b0;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    repeat (10) step();
    check_eq("t4_valid", inst_valid, 32'd1);
    check_eq("t4_pc_top", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    step();
    check_eq("t4_pc_wrap", inst_pc, 32'h0000_0000);

    // Asynchronous reset during REQ with a word on the output
    for (int i = 0; i < 40; i++) begin
      step();
      if (load && inst_valid) break;
    end
    check_eq("t5_found", 32'(load & inst_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_valid", inst_valid, 32'd0);
    check_eq("t5_async_load", load, 32'd0);
    step();
    rst_n = 1'b1;
    wait_load("t5_refetch");
    check_eq("t5_addr", addr, RST_PC);

    // Random backpressure
    p0 = pops;
    for (int i = 0; i < 1000; i++) begin
      step();
      inst_ready = 1'($urandom_range(0, 1));
    end
    check_eq("t6_progress", 32'((pops - p0) >= 150), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port load  output  1  memory instruction-read strobe; memory samples addr on its falling edge.
REQ-005 The block SHALL have port addr  output  32  instruction fetch byte address to memory.
REQ-006 The block SHALL have port data  input  32  instruction word from memory, valid in the cycle after load falls.
REQ-007 The block SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-008 The block SHALL have port redirect_pc  input  32  new fetch target.
REQ-009 The block SHALL have port inst_valid  output  1  inst/inst_pc hold a fetched instruction.
REQ-010 The block SHALL have port inst_ready  input  1  decode accepts the instruction this cycle.
REQ-011 The block SHALL have port inst  output  32  fetched instruction word.
REQ-012 The block SHALL have port inst_pc  output  32  address inst was fetched from.

Function
REQ-013 The block SHALL hold a fetch pc register, a 2-entry FIFO of {pc, inst} pairs, and a 3-state FSM: IDLE, REQ, WAIT.
REQ-014 Room SHALL mean (FIFO count minus 1 if a pop occurs this cycle) < 2 with no request in flight; a request is in flight only in REQ and WAIT.
REQ-015 IDLE: load=0; next state REQ if room, else IDLE.
REQ-016 REQ: load=1, addr=pc; next state WAIT unconditionally.
REQ-017 WAIT: load=0 (falling edge triggers memory read); at end of cycle push {pc, data} into FIFO, pc <= pc+4; next state REQ if room after this push/pop, else IDLE.
REQ-018 Sustained throughput SHALL be one instruction per 2 cycles; REQ-to-inst_valid latency SHALL be 2 cycles with an empty FIFO.
REQ-019 A push SHALL never be dropped; entry to REQ guarantees a free FIFO slot for the following WAIT push.
REQ-020 inst_valid SHALL equal (count != 0); inst/inst_pc SHALL be the FIFO head and SHALL stay stable while inst_valid & !inst_ready.
REQ-021 Pop SHALL occur only on inst_valid & inst_ready; push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 redirect SHALL, in any state, clear the FIFO (count=0), discard any in-flight WAIT data, set pc <= {redirect_pc[31:2], 2'b00}, and force next state IDLE.
REQ-024 A pop coinciding with redirect SHALL count as accepted; the cleared FIFO SHALL not re-present it.
REQ-025 redirect in REQ SHALL still complete the load pulse (load returns to 0 next cycle) but the resulting data SHALL not be pushed.
REQ-026 addr SHALL be registered and change only when entering REQ.

Reset
REQ-027 While rst_n=0, immediately and independent of clk: state=IDLE, pc=RESET_PC, addr=RESET_PC, load=0, count=0, inst_valid=0, inst=0, inst_pc=0.
REQ-028 Reset asserted mid-request (REQ or WAIT) SHALL abandon it; no push after release.
REQ-029 First REQ after release SHALL occur in the second rising edge after rst_n rises.

Verification
REQ-030 Reset release, inst_ready=1, memory holds 32'h00000093 at 0, 32'h00100113 at 4 -> inst_valid with inst_pc=0 inst=32'h00000093, then inst_pc=4 inst=32'h00100113, 2 cycles apart.
REQ-031 inst_ready=0 for 10 cycles -> exactly 2 entries fetched (pc 0, 4), FSM parks in IDLE, load stays 0; raising inst_ready resumes fetch from 8.
REQ-032 redirect=1, redirect_pc=32'h0000_0103 during WAIT -> FIFO empty next cycle, discarded word never appears, next fetch addr=32'h0000_0100.
REQ-033 redirect_pc=32'hFFFF_FFFC -> instructions at inst_pc 32'hFFFF_FFFC then 32'h0000_0000.
REQ-034 rst_n pulsed low during REQ with inst_valid=1 -> inst_valid=0 and load=0 asynchronously; refetch from RESET_PC.
REQ-035 Random inst_ready toggling over 1000 cycles -> inst_pc sequence strictly +4, no duplicate or missing words versus memory image.
